serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_serial_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// ---------------------------------------------------------------------------
// serial_loader : UART command loader (W/R word access, ACK/NAK responses)
// Option macro: SERIAL_LOADER_CHECKSUM_EN (XOR checksum byte on writes)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        error
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef SERIAL_LOADER_CHECKSUM_EN
        CSUM,
`endif
        WRITE,
        READ_REQ,
        READ_WAIT,
        SEND,
        SEND_WAIT
    } state_t;

    state_t      state, state_d;
    logic        is_read, is_read_d;
    logic [1:0]  byte_cnt, byte_cnt_d;
    logic [31:0] gap_cnt, gap_d;
    logic [31:0] shift_reg, shift_d;
    logic [31:0] addr_buf, addr_buf_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [31:0] resp_buf, resp_d;
    logic [2:0]  resp_left, left_d;
    logic        first_wait, first_d;
    logic [31:0] shifted;
    logic        timed_out;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    logic [7:0]  csum, csum_d;
`endif

    assign shifted   = {shift_reg[23:0], rx_byte};
    assign timed_out = (gap_cnt == TIMEOUT_CYCLES);
    assign busy      = (state != IDLE);
    assign tx_byte   = resp_buf[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            byte_cnt   <= 2'd0;
            gap_cnt    <= 32'd0;
            shift_reg  <= 32'd0;
            addr_buf   <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            resp_buf   <= 32'd0;
            resp_left  <= 3'd0;
            first_wait <= 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            state      <= state_d;
            is_read    <= is_read_d;
            byte_cnt   <= byte_cnt_d;
            gap_cnt    <= gap_d;
            shift_reg  <= shift_d;
            addr_buf   <= addr_buf_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_buf   <= resp_d;
            resp_left  <= left_d;
            first_wait <= first_d;
`ifdef SERIAL_LOADER_CHECKSUM_EN
            csum       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        is_read_d   = is_read;
        byte_cnt_d  = byte_cnt;
        gap_d       = 32'd0;
        shift_d     = shift_reg;
        addr_buf_d  = addr_buf;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        resp_d      = resp_buf;
        left_d      = resp_left;
        first_d     = first_wait;
`ifdef SERIAL_LOADER_CHECKSUM_EN
        csum_d      = csum;
`endif
        tx_start    = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        error       = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    byte_cnt_d = 2'd0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
                    csum_d     = rx_byte;
`endif
                    case (rx_byte)
                        CMD_WRITE: begin
                            is_read_d = 1'b0;
                            state_d   = ADDR;
                        end
                        CMD_READ: begin
                            is_read_d = 1'b1;
                            state_d   = ADDR;
                        end
                        default: begin
                            resp_d  = {RSP_NAK, 24'h0};
                            left_d  = 3'd1;
                            state_d = SEND;
                        end
                    endcase
                end
            end
            ADDR: begin
                // A byte in the timeout cycle wins over the abort
                if (rx_valid) begin
                    shift_d    = shifted;
                    byte_cnt_d = byte_cnt + 2'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
                    csum_d     = csum ^ rx_byte;
`endif
                    if (byte_cnt == 2'd3) begin
                        if (is_read) begin
                            mem_addr_d = shifted;
                            state_d    = READ_REQ;
                        end else begin
                            addr_buf_d = shifted;
                            state_d    = DATA;
                        end
                    end
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 32'd1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    shift_d    = shifted;
                    byte_cnt_d = byte_cnt + 2'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
                    csum_d     = csum ^ rx_byte;
                    if (byte_cnt == 2'd3) begin
                        state_d = CSUM;
                    end
`else
                    if (byte_cnt == 2'd3) begin
                        mem_addr_d  = addr_buf;
                        mem_wdata_d = shifted;
                        state_d     = WRITE;
                    end
`endif
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 32'd1;
                end
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum) begin
                        mem_addr_d  = addr_buf;
                        mem_wdata_d = shift_reg;
                        state_d     = WRITE;
                    end else begin
                        resp_d  = {RSP_NAK, 24'h0};
                        left_d  = 3'd1;
                        state_d = SEND;
                    end
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 32'd1;
                end
            end
`endif
            WRITE: begin
                mem_we  = 1'b1;
                resp_d  = {RSP_ACK, 24'h0};
                left_d  = 3'd1;
                state_d = SEND;
            end
            READ_REQ: begin
                mem_re  = 1'b1;
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                resp_d  = mem_rdata;
                left_d  = 3'd4;
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    left_d   = resp_left - 3'd1;
                    first_d  = 1'b1;
                    state_d  = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                // tx_ready may still show the pre-start idle level on the first cycle
                if (first_wait) begin
                    first_d = 1'b0;
                end else if (tx_ready) begin
                    resp_d  = {resp_buf[23:0], 8'h00};
                    state_d = (resp_left != 3'd0) ? SEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_loader : table-driven bench for serial_loader (TIMEOUT_CYCLES=100)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    serial_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .error     (error)
    );

    int          pass_cnt = 0;
    int          total    = 0;
    int          we_cnt   = 0;
    int          re_cnt   = 0;
    int          tx_cnt   = 0;
    int          viol     = 0;
    logic [31:0] tx_log   = 32'd0;
    logic        re_seen  = 1'b0;
    logic [31:0] rd_value = 32'd0;
    int          hold     = 0;
    int          seen     = 0;

    // Bus monitor: strobes, transmitted bytes, tx handshake violations
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            if (mem_we) we_cnt = we_cnt + 1;
            if (mem_re) re_cnt = re_cnt + 1;
            if (tx_start) begin
                tx_log = {tx_log[23:0], tx_byte};
                tx_cnt = tx_cnt + 1;
                if (!tx_ready) viol = viol + 1;
            end
            re_seen = mem_re;
        end else begin
            re_seen = 1'b0;
        end
    end

    // UART transmitter busy for 3 cycles per byte; memory answers one cycle after mem_re
    always @(negedge clk) begin
        if (tx_cnt != seen) begin
            seen     = tx_cnt;
            hold     = 3;
            tx_ready = 1'b0;
        end else if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) tx_ready = 1'b1;
        end
        mem_rdata = re_seen ? rd_value : 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(posedge clk);
            #1;
            if (!busy) done = 1'b1;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_tx(input int target);
        bit done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(posedge clk);
            #1;
            if (tx_cnt >= target) done = 1'b1;
        end
        chk("wait_tx", {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic [79:0] bytes;
        int          nb;
        logic [31:0] rdata;
        int          exp_we;
        int          exp_re;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_tx;
        int          ntx;
    } vec_t;

    vec_t        vecs [5];
    int          we0, re0, tx0, n_err;
    logic [7:0]  b, cs;
    logic [31:0] mask;

    initial begin
        vecs[0] = '{bytes: 80'h57_0000_0010_DEAD_BEEF_00, nb: 9, rdata: 32'h0,
                    exp_we: 1, exp_re: 0, exp_addr: 32'h0000_0010, exp_wdata: 32'hDEAD_BEEF,
                    exp_tx: 32'h0000_0006, ntx: 1};
        vecs[1] = '{bytes: 80'h52_0000_0010_0000_0000_00, nb: 5, rdata: 32'h1234_5678,
                    exp_we: 0, exp_re: 1, exp_addr: 32'h0000_0010, exp_wdata: 32'hDEAD_BEEF,
                    exp_tx: 32'h1234_5678, ntx: 4};
        vecs[2] = '{bytes: 80'h41_0000_0000_0000_0000_00, nb: 1, rdata: 32'h0,
                    exp_we: 0, exp_re: 0, exp_addr: 32'h0000_0010, exp_wdata: 32'hDEAD_BEEF,
                    exp_tx: 32'h0000_0015, ntx: 1};
        vecs[3] = '{bytes: 80'h57_0102_0304_0000_0000_00, nb: 9, rdata: 32'h0,
                    exp_we: 1, exp_re: 0, exp_addr: 32'h0102_0304, exp_wdata: 32'h0000_0000,
                    exp_tx: 32'h0000_0006, ntx: 1};
        vecs[4] = '{bytes: 80'h52_FFFF_FFFC_0000_0000_00, nb: 5, rdata: 32'hA5C3_0F81,
                    exp_we: 0, exp_re: 1, exp_addr: 32'hFFFF_FFFC, exp_wdata: 32'h0000_0000,
                    exp_tx: 32'hA5C3_0F81, ntx: 4};

        rst      = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            rd_value = vecs[i].rdata;
            we0 = we_cnt;
            re0 = re_cnt;
            tx0 = tx_cnt;
            cs  = 8'h00;
            for (int k = 0; k < vecs[i].nb; k++) begin
                b  = vecs[i].bytes[79-8*k -: 8];
                cs = cs ^ b;
                send_byte(b);
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            if (vecs[i].bytes[79:72] == 8'h57) send_byte(cs);
`endif
            wait_idle($sformatf("v%0d_idle", i));
            mask = (vecs[i].ntx == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * vecs[i].ntx)) - 32'd1);
            chk($sformatf("v%0d_we_count", i), we_cnt - we0, vecs[i].exp_we);
            chk($sformatf("v%0d_re_count", i), re_cnt - re0, vecs[i].exp_re);
            chk($sformatf("v%0d_tx_count", i), tx_cnt - tx0, vecs[i].ntx);
            chk($sformatf("v%0d_tx_bytes", i), tx_log & mask, vecs[i].exp_tx);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_tx_ready_viol", i), viol, 0);
        end

`ifdef SERIAL_LOADER_CHECKSUM_EN
        // Bad checksum: NAK and no write
        we0 = we_cnt;
        tx0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h00);
        wait_idle("csum_bad_idle");
        chk("csum_bad_we", we_cnt - we0, 0);
        chk("csum_bad_tx_count", tx_cnt - tx0, 1);
        chk("csum_bad_tx", {24'd0, tx_log[7:0]}, 32'h15);
`endif

        // Timeout: silence after a partial address
        we0 = we_cnt;
        tx0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        n_err = -1;
        for (int n = 1; n <= 300 && n_err < 0; n++) begin
            @(posedge clk);
            #1;
            if (error) n_err = n;
        end
        chk("timeout_gap", n_err, 100);
        @(posedge clk);
        #1;
        chk("timeout_error_pulse", {31'd0, error}, 32'd0);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_we", we_cnt - we0, 0);
        chk("timeout_no_tx", tx_cnt - tx0, 0);
        rd_value = 32'h600D_CAFE;
        re0 = re_cnt;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_idle("after_timeout_idle");
        chk("after_timeout_re", re_cnt - re0, 1);
        chk("after_timeout_tx", tx_log, 32'h600D_CAFE);

        // Bytes arriving during a response are discarded
        rd_value = 32'hCAFE_0001;
        tx0 = tx_cnt;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        wait_tx(tx0 + 1);
        send_byte(8'h57);
        wait_idle("discard_idle");
        chk("discard_tx_count", tx_cnt - tx0, 4);
        chk("discard_tx", tx_log, 32'hCAFE_0001);
        chk("discard_addr", mem_addr, 32'h0000_0040);

        // Reset in the middle of a read response
        rd_value = 32'h1122_3344;
        tx0 = tx_cnt;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        wait_tx(tx0 + 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tx0 = tx_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_tx", tx_cnt - tx0, 0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h41);
        wait_idle("postrst_idle");
        chk("postrst_tx_count", tx_cnt - tx0, 1);
        chk("postrst_nak", {24'd0, tx_log[7:0]}, 32'h15);
        chk("final_tx_ready_viol", viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
